// File: rtl/range_finder_stats_if.sv
// range_finder_stats_if
//   Groups the sample-session bus of range_finder_stats into one bundle.
//   The sample source drives data_in, go, finish and signed_mode. The
//   statistics block returns range, min_out, max_out, count, valid and
//   debug_error.
//
//   Modports:
//     slave  - the statistics block (takes the session inputs, drives the results)
//     master - the sample source / consumer (drives the session inputs)
//
//   Parameters:
//     WIDTH - sample width in bits
//     CNT_W - sample-counter width in bits
interface range_finder_stats_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic             signed_mode;
  logic [WIDTH-1:0] range;
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             debug_error;

  modport slave (
    input  data_in, go, finish, signed_mode,
    output range, min_out, max_out, count, valid, debug_error
  );

  modport master (
    output data_in, go, finish, signed_mode,
    input  range, min_out, max_out, count, valid, debug_error
  );

endinterface

// File: rtl/range_finder_stats.sv
// range_finder_stats
//   Tracks the minimum, maximum, range (max - min) and sample count over a
//   session that is opened by go and closed by finish. A sample is taken on
//   every cycle while the session is open, including the go cycle and the
//   finish cycle. The comparison mode (signed or unsigned) is latched at go.
//   The sample counter saturates at 2^CNT_W - 1. On the cycle after finish,
//   the results load and valid pulses for one cycle. Protocol misuse sets a
//   sticky debug_error flag. The flag clears on the next accepted go.
//
//   Ports:
//     clock  - system clock; all state updates on the rising edge
//     reset  - synchronous, active-high reset; wins over every other input
//     bus    - range_finder_stats_if.slave:
//                data_in, go, finish, signed_mode (in)
//                range, min_out, max_out, count, valid, debug_error (out)
//
//   Parameters:
//     WIDTH - sample width in bits (>= 2); must match the interface
//     CNT_W - sample-counter width in bits; must match the interface
module range_finder_stats #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  range_finder_stats_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] cur_min;
  logic [WIDTH-1:0] cur_max;
  logic [CNT_W-1:0] cnt;
  logic             mode;

  logic             start;
  logic             accumulate;
  logic             close;
  logic             err_set;

  logic             below_min;
  logic             above_max;
  logic [WIDTH-1:0] min_next;
  logic [WIDTH-1:0] max_next;
  logic [CNT_W-1:0] cnt_next;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. A go that arrives with finish in IDLE
  // would be a single-cycle session. That case is treated as an error and
  // nothing is captured.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accumulate = 1'b0;
    close      = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.go && !bus.finish) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end else if (bus.finish) begin
          err_set = 1'b1;
        end
      end
      ACTIVE: begin
        accumulate = 1'b1;
        if (bus.go) begin
          err_set = 1'b1;
        end
        if (bus.finish) begin
          close      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Running extremes, including the current sample, compared in the
  // latched mode. These values are also what close loads. The finish
  // sample is therefore part of the reported result.
  always_comb begin
    if (mode) begin
      below_min = $signed(bus.data_in) < $signed(cur_min);
      above_max = $signed(bus.data_in) > $signed(cur_max);
    end else begin
      below_min = bus.data_in < cur_min;
      above_max = bus.data_in > cur_max;
    end
    min_next = below_min ? bus.data_in : cur_min;
    max_next = above_max ? bus.data_in : cur_max;
    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  // Session datapath and result registers. The range is a plain WIDTH-bit
  // subtraction of the raw patterns. In both modes the true difference fits
  // in WIDTH unsigned bits, so the result is exact.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_min         <= '0;
      cur_max         <= '0;
      cnt             <= '0;
      mode            <= 1'b0;
      bus.range       <= '0;
      bus.min_out     <= '0;
      bus.max_out     <= '0;
      bus.count       <= '0;
      bus.valid       <= 1'b0;
      bus.debug_error <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (start) begin
        cur_min         <= bus.data_in;
        cur_max         <= bus.data_in;
        cnt             <= CNT_W'(1);
        mode            <= bus.signed_mode;
        bus.debug_error <= 1'b0;
      end
      if (accumulate) begin
        cur_min <= min_next;
        cur_max <= max_next;
        cnt     <= cnt_next;
      end
      if (err_set) begin
        bus.debug_error <= 1'b1;
      end
      if (close) begin
        bus.min_out <= min_next;
        bus.max_out <= max_next;
        bus.range   <= max_next - min_next;
        bus.count   <= cnt_next;
        bus.valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_range_finder_stats.sv
// tb_range_finder_stats
//   Self-checking bench for range_finder_stats. The bench uses WIDTH=8 and
//   CNT_W=4, so counter saturation is reachable with a 20-sample session.
//   A queue-based session model predicts every output on every cycle. A
//   compare process checks the DUT against the model. Directed checks with
//   hand-computed literals pin both the model and the DUT at key points.
module tb_range_finder_stats;

  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic clock;
  logic reset;

  range_finder_stats_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  range_finder_stats #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run  = 0;
  int fail_count = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Session model: collect the samples of a session in a queue and derive
  // the results directly from the full list when the session closes.
  logic [W-1:0]  samples[$];
  bit            sess_open  = 0;
  bit            sess_sign  = 0;
  bit            model_live = 0;
  logic [W-1:0]  exp_min    = '0;
  logic [W-1:0]  exp_max    = '0;
  logic [W-1:0]  exp_range  = '0;
  logic [CW-1:0] exp_count  = '0;
  logic          exp_valid  = 1'b0;
  logic          exp_err    = 1'b0;

  function automatic int sampleValue(input logic [W-1:0] s, input bit sgn);
    return sgn ? int'($signed(s)) : int'({24'd0, s});
  endfunction

  always @(posedge clock) begin
    int lo;
    int hi;
    int n;
    model_live = 1;
    exp_valid  = 1'b0;
    if (reset) begin
      sess_open = 0;
      samples.delete();
      exp_min   = '0;
      exp_max   = '0;
      exp_range = '0;
      exp_count = '0;
      exp_err   = 1'b0;
    end else if (!sess_open) begin
      if (bus.go && !bus.finish) begin
        sess_open = 1;
        sess_sign = bus.signed_mode;
        samples.delete();
        samples.push_back(bus.data_in);
        exp_err = 1'b0;
      end else if (bus.finish) begin
        exp_err = 1'b1;
      end
    end else begin
      samples.push_back(bus.data_in);
      if (bus.go) exp_err = 1'b1;
      if (bus.finish) begin
        lo = sampleValue(samples[0], sess_sign);
        hi = lo;
        foreach (samples[i]) begin
          if (sampleValue(samples[i], sess_sign) < lo) lo = sampleValue(samples[i], sess_sign);
          if (sampleValue(samples[i], sess_sign) > hi) hi = sampleValue(samples[i], sess_sign);
        end
        n         = samples.size();
        exp_min   = lo[W-1:0];
        exp_max   = hi[W-1:0];
        n         = hi - lo;
        exp_range = n[W-1:0];
        n         = (samples.size() > CNT_MAX) ? CNT_MAX : samples.size();
        exp_count = n[CW-1:0];
        exp_valid = 1'b1;
        sess_open = 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (model_live) begin
      checkOutput("cyc_min",   32'(bus.min_out),     32'(exp_min));
      checkOutput("cyc_max",   32'(bus.max_out),     32'(exp_max));
      checkOutput("cyc_range", 32'(bus.range),       32'(exp_range));
      checkOutput("cyc_count", 32'(bus.count),       32'(exp_count));
      checkOutput("cyc_valid", 32'(bus.valid),       32'(exp_valid));
      checkOutput("cyc_err",   32'(bus.debug_error), 32'(exp_err));
    end
  end

  // Drive one cycle of inputs, applied at the falling edge
  task automatic applyStimulus(input logic g, input logic f, input logic s,
                               input logic [W-1:0] d);
    @(negedge clock);
    reset           = 1'b0;
    bus.go          = g;
    bus.finish      = f;
    bus.signed_mode = s;
    bus.data_in     = d;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] mn,
                             input logic [W-1:0] mx, input logic [W-1:0] rg,
                             input int cnt, input logic vld, input logic err);
    checkOutput({tag, "_min"},   32'(bus.min_out),     32'(mn));
    checkOutput({tag, "_max"},   32'(bus.max_out),     32'(mx));
    checkOutput({tag, "_range"}, 32'(bus.range),       32'(rg));
    checkOutput({tag, "_count"}, 32'(bus.count),       32'(cnt));
    checkOutput({tag, "_valid"}, 32'(bus.valid),       32'(vld));
    checkOutput({tag, "_err"},   32'(bus.debug_error), 32'(err));
  endtask

  initial begin
    reset           = 1'b1;
    bus.go          = 1'b0;
    bus.finish      = 1'b0;
    bus.signed_mode = 1'b0;
    bus.data_in     = '0;
    repeat (2) @(negedge clock);
    checkResult("reset", 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);

    // Unsigned session: 40, 10, F0, 80
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hF0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h80);
    applyIdle();
    checkResult("unsigned", 8'h10, 8'hF0, 8'hE0, 4, 1'b1, 1'b0);
    applyIdle();
    checkResult("hold", 8'h10, 8'hF0, 8'hE0, 4, 1'b0, 1'b0);

    // Signed session: +127, -128, 0
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h7F);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyIdle();
    checkResult("signed", 8'h80, 8'h7F, 8'hFF, 3, 1'b1, 1'b0);

    // go together with finish in IDLE: error, nothing captured, stays IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    applyIdle();
    checkResult("gofin", 8'h80, 8'h7F, 8'hFF, 3, 1'b0, 1'b1);

    // Accepted go clears the error; go inside the session sets it again
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h06);
    checkOutput("go_clears_err", 32'(bus.debug_error), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h09);
    checkOutput("active_go_err", 32'(bus.debug_error), 32'd1);
    applyIdle();
    checkResult("errsess", 8'h03, 8'h09, 8'h06, 4, 1'b1, 1'b1);

    // 20-sample unsigned session: the count saturates at 15
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i == 0, i == 19, 1'b0, 8'(i + 1));
    end
    // Back-to-back: the new go lands on the valid cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE);
    checkResult("saturate", 8'h01, 8'h14, 8'h13, CNT_MAX, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    applyIdle();
    checkResult("b2b", 8'hFE, 8'h03, 8'h05, 3, 1'b1, 1'b0);

    // finish in IDLE: error flag, no strobe, results unchanged
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
    applyIdle();
    checkResult("idlefin", 8'hFE, 8'h03, 8'h05, 3, 1'b0, 1'b1);

    // Reset in the middle of a session discards it
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h50);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h60);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h70);
    @(negedge clock);
    reset      = 1'b1;
    bus.go     = 1'b0;
    bus.finish = 1'b0;
    @(negedge clock);
    checkResult("midreset", 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
    applyIdle();
    checkResult("postreset", 8'h22, 8'h33, 8'h11, 2, 1'b1, 1'b0);
    applyIdle();
    applyIdle();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
